mem32_initiator: RTL and testbench

- Initiator-side adapter for the 32-bit single-ported memory: accepts byte, halfword and word load/store requests at byte addresses from the core.
- Drives the memory port: valid, write, wmask, wdata, word address; read data returns one cycle after the address is presented.
- Aligns store data into byte lanes and extracts/sign-extends load data.
- Splits word-crossing misaligned accesses into two back-to-back memory cycles.
- Aligned traffic runs at one request per cycle.

---
 rtl/mem32_initiator_pkg.sv | 28 ++
 rtl/mem32_load_extract.sv | 38 +++
 rtl/mem32_initiator.sv | 147 ++++++++++++++
 tb/tb_mem32_initiator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem32_initiator_pkg.sv
// Shared definitions for the 32-bit memory initiator: access size codes,
// FSM state encoding and the byte-lane mask helper.
package mem32_initiator_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    // Byte lanes touched by an access, 8 lanes wide so that a word-crossing
    // access shows its second-word lanes in the high nibble.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SIZE_BYTE: base = 8'b0000_0001;
            SIZE_HALF: base = 8'b0000_0011;
            SIZE_WORD: base = 8'b0000_1111;
            default:   base = 8'b0000_0000;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/mem32_load_extract.sv
// Load data extraction: shifts a 64-bit two-word window right by the byte
// offset and sign/zero-extends the selected byte, half or word.
module mem32_load_extract
    import mem32_initiator_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [63:0] shifted_s;

    // Select and extend the addressed bytes.
    always_comb begin
        shifted_s = window >> {off, 3'b000};
        case (size)
            SIZE_BYTE: begin
                if (uns) begin
                    data = {24'h00_0000, shifted_s[7:0]};
                end else begin
                    data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SIZE_HALF: begin
                if (uns) begin
                    data = {16'h0000, shifted_s[15:0]};
                end else begin
                    data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SIZE_WORD: data = shifted_s[31:0];
            default:   data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem32_initiator.sv
// Core-side byte/half/word load-store adapter for a 32-bit single-ported
// memory. Aligned accesses take one memory cycle; word-crossing accesses are
// split into two back-to-back cycles. Read data arrives one cycle after the
// address, so load results are formed combinationally in the response cycle.
module mem32_initiator
    import mem32_initiator_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH+1:0] req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_error,
    output logic             mem_valid,
    output logic             mem_write,
    output logic [3:0]       mem_wmask,
    output logic [31:0]      mem_wdata,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [31:0]      mem_rdata
);

    state_t           state_r, state_s;
    logic             accept_s, legal_s, cross_s;
    logic [7:0]       mask_s;
    logic [63:0]      wide_s;
    logic [WIDTH-1:0] next_word_s;
    logic [63:0]      window_s;
    logic [31:0]      extract_s;

    // Captured request attributes for the response / second access.
    logic [1:0]       size_r;
    logic [1:0]       off_r;
    logic             uns_r;
    logic             write_r;
    logic             split_r;
    logic [3:0]       hi_mask_r;
    logic [31:0]      hi_wdata_r;
    logic [WIDTH-1:0] addr2_r;
    logic [31:0]      word1_r;
    logic             resp_valid_r;
    logic             resp_error_r;

    assign req_ready   = (state_r == IDLE);
    assign accept_s    = req_valid & req_ready;
    assign legal_s     = (req_size != SIZE_ILLEGAL);
    assign mask_s      = lane_mask(req_size, req_addr[1:0]);
    assign cross_s     = legal_s & (mask_s[7:4] != 4'b0000);
    assign wide_s      = {32'h0000_0000, req_wdata} << {req_addr[1:0], 3'b000};
    assign next_word_s = req_addr[WIDTH+1:2] + {{(WIDTH-1){1'b0}}, 1'b1};

    // Next state and memory port drive.
    always_comb begin
        state_s   = state_r;
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_wmask = 4'b0000;
        mem_wdata = 32'h0000_0000;
        mem_addr  = req_addr[WIDTH+1:2];
        case (state_r)
            IDLE: begin
                if (accept_s && legal_s) begin
                    mem_valid = 1'b1;
                    mem_write = req_write & (mask_s[3:0] != 4'b0000);
                    mem_wmask = mask_s[3:0];
                    mem_wdata = wide_s[31:0];
                    if (cross_s) begin
                        state_s = SECOND;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SECOND: begin
                mem_valid = 1'b1;
                mem_write = write_r & (hi_mask_r != 4'b0000);
                mem_wmask = hi_mask_r;
                mem_wdata = hi_wdata_r;
                mem_addr  = addr2_r;
                state_s   = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, request capture and response flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            size_r       <= 2'b00;
            off_r        <= 2'b00;
            uns_r        <= 1'b0;
            write_r      <= 1'b0;
            split_r      <= 1'b0;
            hi_mask_r    <= 4'b0000;
            hi_wdata_r   <= 32'h0000_0000;
            addr2_r      <= {WIDTH{1'b0}};
            word1_r      <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            if (state_r == SECOND) begin
                word1_r      <= mem_rdata;
                resp_valid_r <= 1'b1;
            end else if (accept_s) begin
                size_r       <= req_size;
                off_r        <= req_addr[1:0];
                uns_r        <= req_unsigned;
                write_r      <= req_write;
                split_r      <= cross_s;
                hi_mask_r    <= mask_s[7:4];
                hi_wdata_r   <= wide_s[63:32];
                addr2_r      <= next_word_s;
                resp_valid_r <= ~cross_s;
                resp_error_r <= ~legal_s;
            end
        end
    end

    // Split loads see {second word, first word}; aligned loads see one word.
    assign window_s = split_r ? {mem_rdata, word1_r} : {32'h0000_0000, mem_rdata};

    mem32_load_extract u_extract (
        .window (window_s),
        .off    (off_r),
        .size   (size_r),
        .uns    (uns_r),
        .data   (extract_s)
    );

    assign resp_valid = resp_valid_r;
    assign resp_error = resp_error_r;
    assign resp_rdata = (resp_valid_r && !resp_error_r && !write_r) ? extract_s : 32'h0000_0000;

endmodule

// File: tb/tb_mem32_initiator.sv
// Directed and randomized bench for mem32_initiator against a byte-array
// reference model of memory.
module tb_mem32_initiator;

    localparam int WIDTH = 13;
    localparam int ABITS = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [1:0]       req_size = 2'd0;
    logic             req_unsigned = 1'b0;
    logic [ABITS-1:0] req_addr = '0;
    logic [31:0]      req_wdata = 32'h0;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_error;
    logic             mem_valid;
    logic             mem_write;
    logic [3:0]       mem_wmask;
    logic [31:0]      mem_wdata;
    logic [WIDTH-1:0] mem_addr;
    logic [31:0]      mem_rdata = 32'h0;
    logic             mem_clear = 1'b1;

    logic [31:0] tb_mem [0:(1<<WIDTH)-1];
    logic [7:0]  ref_mem [0:(1<<ABITS)-1];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem32_initiator #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    // Single-port memory: read data one cycle after the address, lane writes.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < (1 << WIDTH); i++) tb_mem[i] <= 32'h0;
        end else begin
            mem_rdata <= tb_mem[mem_addr];
            if (mem_valid && mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (mem_wmask[i]) tb_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd3) ? 0 : (1 << size);
    endfunction

    function automatic logic [31:0] ref_load(input logic [ABITS-1:0] addr, input logic [1:0] size, input logic uns);
        logic [31:0] v;
        logic [ABITS-1:0] a;
        int n;
        n = nbytes(size);
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            a = addr + ABITS'(i);
            v[8*i +: 8] = ref_mem[a];
        end
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        return v;
    endfunction

    task automatic ref_store(input logic [ABITS-1:0] addr, input int n, input logic [31:0] wdata);
        logic [ABITS-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + ABITS'(i);
            ref_mem[a] = wdata[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [WIDTH-1:0] w);
        logic [ABITS-1:0] b;
        logic [31:0] v;
        b = {w, 2'b00};
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[b + ABITS'(i)];
        return v;
    endfunction

    // One complete request; entered and left at a falling edge.
    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [ABITS-1:0] addr, input logic [31:0] wdata,
                          input string tag, output logic [31:0] got);
        int n;
        logic crossing;
        logic [31:0] exp;
        logic [WIDTH-1:0] w1, w2;
        n = nbytes(size);
        crossing = (n != 0) && (int'(addr[1:0]) + n > 4);
        exp = (n != 0 && !wr) ? ref_load(addr, size, uns) : 32'h0;
        w1 = addr[ABITS-1:2];
        w2 = w1 + WIDTH'(1);
        req_valid = 1'b1; req_write = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
        check({tag, " mem_valid T"}, {31'h0, mem_valid}, {31'h0, (n != 0)});
        if (n != 0) check({tag, " mem_addr T"}, {19'h0, mem_addr}, {19'h0, w1});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (wr && n != 0) ref_store(addr, n, wdata);
        @(negedge clk);
        if (crossing) begin
            check({tag, " resp early"}, {31'h0, resp_valid}, 32'h0);
            check({tag, " ready split"}, {31'h0, req_ready}, 32'h0);
            check({tag, " mem_addr T+1"}, {19'h0, mem_addr}, {19'h0, w2});
            @(negedge clk);
        end else begin
            check({tag, " single cycle"}, {31'h0, mem_valid}, 32'h0);
        end
        check({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
        check({tag, " resp_error"}, {31'h0, resp_error}, {31'h0, (n == 0)});
        check({tag, " resp_rdata"}, resp_rdata, exp);
        got = resp_rdata;
    endtask

    initial begin
        logic [31:0] got;
        logic [1:0] sz;
        logic [ABITS-1:0] ad;
        for (int i = 0; i < (1 << ABITS); i++) ref_mem[i] = 8'h00;

        // Reset and memory clear.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst resp_error", {31'h0, resp_error}, 32'h0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rst mem_write", {31'h0, mem_write}, 32'h0);
        check("rst mem_wmask", {28'h0, mem_wmask}, 32'h0);
        mem_clear = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check("rst ready", {31'h0, req_ready}, 32'h1);

        // Preload words 0x10 and 0x11 through the DUT.
        do_req(1'b1, 2'd2, 1'b0, 15'h0040, 32'h8877_6655, "pre0", got);
        do_req(1'b1, 2'd2, 1'b0, 15'h0044, 32'h0403_0201, "pre1", got);

        do_req(1'b0, 2'd0, 1'b1, 15'h0041, 32'h0, "ldbu", got);
        check("plan ldbu", got, 32'h0000_0066);

        // Back-to-back aligned loads.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 15'h0042;
        #1;
        check("b2b mem_valid", {31'h0, mem_valid}, 32'h1);
        @(negedge clk);
        check("b2b resp1 valid", {31'h0, resp_valid}, 32'h1);
        check("b2b resp1 data", resp_rdata, 32'hFFFF_8877);
        check("b2b ready1", {31'h0, req_ready}, 32'h1);
        req_size = 2'd2; req_addr = 15'h0040;
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b resp2 valid", {31'h0, resp_valid}, 32'h1);
        check("b2b resp2 data", resp_rdata, 32'h8877_6655);
        check("b2b ready2", {31'h0, req_ready}, 32'h1);

        do_req(1'b0, 2'd2, 1'b0, 15'h0043, 32'h0, "ldw43", got);
        check("plan ldw43", got, 32'h0302_0188);

        // Split word store with lane checks.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 15'h0046; req_wdata = 32'hAABB_CCDD;
        #1;
        check("st46 a1 addr", {19'h0, mem_addr}, 32'h11);
        check("st46 a1 mask", {28'h0, mem_wmask}, 32'hC);
        check("st46 a1 data", mem_wdata, 32'hCCDD_0000);
        check("st46 a1 write", {31'h0, mem_write}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ref_store(15'h0046, 4, 32'hAABB_CCDD);
        @(negedge clk);
        check("st46 a2 addr", {19'h0, mem_addr}, 32'h12);
        check("st46 a2 mask", {28'h0, mem_wmask}, 32'h3);
        check("st46 a2 data", mem_wdata, 32'h0000_AABB);
        check("st46 a2 write", {31'h0, mem_write}, 32'h1);
        @(negedge clk);
        check("st46 resp", {31'h0, resp_valid}, 32'h1);
        check("st46 rdata", resp_rdata, 32'h0);
        check("st46 mem11", tb_mem[13'h11], 32'hCCDD_0201);
        check("st46 mem12", tb_mem[13'h12], 32'h0000_AABB);
        do_req(1'b0, 2'd2, 1'b0, 15'h0046, 32'h0, "ld46", got);

        // Wrap at the top of the address space.
        do_req(1'b1, 2'd1, 1'b0, 15'h7FFF, 32'h1234_ABCD, "sthtop", got);
        do_req(1'b0, 2'd1, 1'b0, 15'h7FFF, 32'h0, "ldhtop", got);
        check("plan ldhtop", got, 32'hFFFF_ABCD);

        do_req(1'b0, 2'd3, 1'b0, 15'h0040, 32'h0, "illegal", got);

        // Reset during the second half of a split store.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 15'h0045; req_wdata = 32'h5A6B_7C8D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ref_store(15'h0045, 3, 32'h5A6B_7C8D);
        @(negedge clk);
        check("rsts in second", {31'h0, req_ready}, 32'h0);
        rstn = 1'b0;
        #1;
        check("rsts mem_valid", {31'h0, mem_valid}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        check("rsts no resp a", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        check("rsts no resp b", {31'h0, resp_valid}, 32'h0);
        check("rsts ready", {31'h0, req_ready}, 32'h1);
        check("rsts mem11", tb_mem[13'h11], ref_word(13'h11));
        check("rsts mem12", tb_mem[13'h12], ref_word(13'h12));

        // Randomized traffic against the byte model.
        for (int k = 0; k < 400; k++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) ad = 15'h7FF8 + 15'($urandom_range(0, 7));
            else ad = 15'h0200 + 15'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, "rnd", got);
        end
        for (int w = 16'h80; w < 16'h91; w++)
            check("final mem", tb_mem[w], ref_word(WIDTH'(w)));
        check("final mem top", tb_mem[13'h1FFF], ref_word(13'h1FFF));
        check("final mem 0", tb_mem[13'h0000], ref_word(13'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
